// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential IEEE 754 adder/subtractor:
// format defaults, FSM encoding, flag positions and the canonical quiet NaN.
package fpu_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_ADD   = 3'd2,
      ST_NORM  = 3'd3,
      ST_ROUND = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam int FLAG_INEXACT  = 0;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_INVALID  = 2;

   // {sign=0, exponent all ones, mantissa MSB set}, right-aligned in 64 bits
   function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
      v[man_w - 1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fpu_lzc #(
   parameter  int WIDTH = 27,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] value,
   output logic [CW-1:0]    count
);

   // Scanning upward lets the highest set bit make the final assignment.
   always_comb begin
      count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) count = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE 754 adder/subtractor (RNE, flush-to-zero), one operation in flight.
// Handshake: a transfer occurs on a rising edge with valid and ready both high; in_ready is
// high only in IDLE, and out_valid holds result/flags stable until out_ready accepts them.
module fpu_addsub_seq
   import fpu_pkg::*;
#(
   parameter  int EXP_W = EXP_W_DEF,
   parameter  int MAN_W = MAN_W_DEF,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op_sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [2:0]   flags
);

   localparam int XW  = MAN_W + 4;   // hidden, mantissa, G, R, S
   localparam int SW  = MAN_W + 5;   // XW plus carry
   localparam int EW  = EXP_W + 2;   // signed working exponent
   localparam int LZW = $clog2(XW + 1);
   localparam logic [63:0]          NAN64     = canon_nan(EXP_W, MAN_W);
   localparam logic [W-1:0]         CANON_NAN = NAN64[W-1:0];
   localparam logic [EXP_W-1:0]     SHIFT_MAX = EXP_W'(MAN_W + 3);
   localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_W) - 1);

   state_t                state;
   logic [W-1:0]          op_a_r, op_b_r;
   logic                  sign_r, eff_sub_r, special_r;
   logic signed [EW-1:0]  exp_r;
   logic [XW-1:0]         man_a_r, man_b_r;
   logic [SW-1:0]         sum_r;

   logic                  a_sgn, b_sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [EXP_W-1:0]      a_exp, b_exp, big_exp, small_exp, diff;
   logic [MAN_W-1:0]      a_man, b_man, big_man, small_man;
   logic [W-2:0]          mag_a, mag_b;
   logic                  swap, big_sgn, small_zero, lost, spec_hit;
   logic [XW-1:0]         small_x, shifted, man_b_next;
   logic [W-1:0]          spec_res;
   logic [2:0]            spec_flags;

   assign a_sgn  = op_a_r[W-1];
   assign b_sgn  = op_b_r[W-1];
   assign a_exp  = op_a_r[W-2 -: EXP_W];
   assign b_exp  = op_b_r[W-2 -: EXP_W];
   assign a_man  = op_a_r[MAN_W-1:0];
   assign b_man  = op_b_r[MAN_W-1:0];
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign a_inf  = (&a_exp) && (a_man == '0);
   assign b_inf  = (&b_exp) && (b_man == '0);
   assign a_nan  = (&a_exp) && (a_man != '0);
   assign b_nan  = (&b_exp) && (b_man != '0);
   assign mag_a  = a_zero ? '0 : op_a_r[W-2:0];
   assign mag_b  = b_zero ? '0 : op_b_r[W-2:0];

   always_comb begin
      swap       = mag_b > mag_a;
      big_sgn    = swap ? b_sgn : a_sgn;
      big_exp    = swap ? b_exp : a_exp;
      big_man    = swap ? b_man : a_man;
      small_exp  = swap ? a_exp : b_exp;
      small_man  = swap ? a_man : b_man;
      small_zero = swap ? a_zero : b_zero;
      diff       = big_exp - small_exp;
      small_x    = {1'b1, small_man, 3'b000};
      shifted    = small_x >> diff;
      lost       = |(small_x & ~({XW{1'b1}} << diff));
      if (small_zero)             man_b_next = '0;
      else if (diff >= SHIFT_MAX) man_b_next = {{(XW-1){1'b0}}, 1'b1};
      else                        man_b_next = {shifted[XW-1:1], shifted[0] | lost};

      spec_hit   = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
      spec_flags = '0;
      if (a_nan | b_nan) begin
         spec_res = CANON_NAN;
      end else if (a_inf & b_inf & (a_sgn != b_sgn)) begin
         spec_res = CANON_NAN;
         spec_flags[FLAG_INVALID] = 1'b1;
      end else if (a_inf) begin
         spec_res = op_a_r;
      end else if (b_inf) begin
         spec_res = op_b_r;
      end else begin
         spec_res = {a_sgn & b_sgn, {(W-1){1'b0}}};
      end
   end

   logic [LZW-1:0]       lz;
   logic                 carry;
   logic signed [EW-1:0] exp_norm;
   logic [XW-1:0]        man_norm;

   fpu_lzc #(.WIDTH(XW)) u_lzc (
      .value (sum_r[XW-1:0]),
      .count (lz)
   );

   always_comb begin
      carry = sum_r[SW-1];
      if (carry) begin
         exp_norm = exp_r + EW'(1);
         man_norm = {sum_r[SW-1:2], sum_r[1] | sum_r[0]};
      end else begin
         exp_norm = exp_r - $signed({{(EW-LZW){1'b0}}, lz});
         man_norm = sum_r[XW-1:0] << lz;
      end
   end

   logic                 rnd_up, inexact;
   logic [MAN_W+1:0]     mant_rnd;
   logic [MAN_W-1:0]     frac_rnd;
   logic signed [EW-1:0] exp_rnd;
   logic [2:0]           rnd_flags;
   logic [W-1:0]         rnd_res;

   always_comb begin
      inexact  = |man_a_r[2:0];
      rnd_up   = man_a_r[2] & (man_a_r[1] | man_a_r[0] | man_a_r[3]);
      mant_rnd = {1'b0, man_a_r[XW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
      exp_rnd  = exp_r + EW'(mant_rnd[MAN_W+1]);
      frac_rnd = mant_rnd[MAN_W+1] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
      rnd_flags = '0;
      rnd_flags[FLAG_INEXACT] = inexact;
      if (exp_rnd >= EXP_MAX) begin
         rnd_res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rnd_flags[FLAG_OVERFLOW] = 1'b1;
         rnd_flags[FLAG_INEXACT]  = 1'b1;
      end else begin
         rnd_res = {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
         op_a_r    <= '0;
         op_b_r    <= '0;
         sign_r    <= 1'b0;
         eff_sub_r <= 1'b0;
         special_r <= 1'b0;
         exp_r     <= '0;
         man_a_r   <= '0;
         man_b_r   <= '0;
         sum_r     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_a_r   <= a;
                  op_b_r   <= b ^ {op_sub, {(W-1){1'b0}}};
                  in_ready <= 1'b0;
                  state    <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               special_r <= spec_hit;
               result    <= spec_res;
               flags     <= spec_flags;
               sign_r    <= big_sgn;
               eff_sub_r <= a_sgn ^ b_sgn;
               exp_r     <= {2'b00, big_exp};
               man_a_r   <= {1'b1, big_man, 3'b000};
               man_b_r   <= man_b_next;
               state     <= ST_ADD;
            end
            ST_ADD: begin
               sum_r <= eff_sub_r ? ({1'b0, man_a_r} - {1'b0, man_b_r})
                                  : ({1'b0, man_a_r} + {1'b0, man_b_r});
               state <= ST_NORM;
            end
            ST_NORM: begin
               // Exact cancellation gives +0; a non-positive exponent flushes to signed zero.
               if (!special_r) begin
                  if (sum_r == '0) begin
                     special_r <= 1'b1;
                     result    <= '0;
                     flags     <= '0;
                  end else if (exp_norm[EW-1] || exp_norm == '0) begin
                     special_r <= 1'b1;
                     result    <= {sign_r, {(W-1){1'b0}}};
                     flags     <= 3'b001 << FLAG_INEXACT;
                  end else begin
                     exp_r   <= exp_norm;
                     man_a_r <= man_norm;
                  end
               end
               state <= ST_ROUND;
            end
            ST_ROUND: begin
               if (!special_r) begin
                  result <= rnd_res;
                  flags  <= rnd_flags;
               end
               out_valid <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Scoreboard bench for fpu_addsub_seq with hand-computed FP32 vectors,
// back-pressure and mid-operation reset scenarios.
module tb_fpu_addsub_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [2:0]   flags;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [W-1:0] exp_q[$];
   logic [2:0]   exp_flags_q[$];
   int           exp_cyc_q[$];

   fpu_addsub_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                       input logic [W-1:0] er, input logic [2:0] ef);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed %b expected 1", in_ready);
         return;
      end
      a        = ta;
      b        = tbv;
      op_sub   = ts;
      in_valid = 1'b1;
      exp_q.push_back(er);
      exp_flags_q.push_back(ef);
      exp_cyc_q.push_back(cyc + 5);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((exp_q.size() != 0 || !in_ready) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0 || !in_ready) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: pending %0d in_ready %b expected 0 and 1", exp_q.size(), in_ready);
      end
   endtask

   // monitor: compares each new result against the scoreboard head
   initial begin : monitor
      logic         prev_v;
      logic [W-1:0] e_res;
      logic [2:0]   e_fl;
      int           e_cyc;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_v = 1'b0;
         end else begin
            if (out_valid && !prev_v) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got result %h with nothing pending", result);
               end else begin
                  e_res = exp_q.pop_front();
                  e_fl  = exp_flags_q.pop_front();
                  e_cyc = exp_cyc_q.pop_front();
                  check("result",  64'(result), 64'(e_res));
                  check("flags",   64'(flags),  64'(e_fl));
                  check("latency", 64'(cyc),    64'(e_cyc));
               end
            end
            prev_v = out_valid;
         end
      end
   end

   initial begin : watchdog
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : driver
      int guard;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op_sub    = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result",    64'(result),    64'd0);
      check("rst_flags",     64'(flags),     64'd0);
      rst_n = 1'b1;

      send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
      send(32'h3FC00000, 32'h40000000, 1'b1, 32'hBF000000, 3'b000);
      send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
      send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
      send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
      send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
      send(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
      send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
      send(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
      send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
      send(32'h3F800000, 32'h7F800001, 1'b0, 32'h7FC00000, 3'b000);
      send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
      send(32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 3'b000);
      send(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 3'b000);
      send(32'h3F800000, 32'h2F800000, 1'b0, 32'h3F800000, 3'b001);
      send(32'h3F800000, 32'h2F800000, 1'b1, 32'h3F800000, 3'b001);
      send(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000);
      send(32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 3'b011);
      send(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001);
      send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
      send(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000);
      wait_idle();

      // back-pressure with a competing request held on the input
      out_ready = 1'b0;
      send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000);
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      a        = 32'h3F800000;
      b        = 32'h3F800000;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_result",    64'(result),    64'h40800000);
         check("bp_in_ready",  64'(in_ready),  64'd0);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("hs_in_ready",  64'(in_ready),  64'd1);
      check("hs_out_valid", 64'(out_valid), 64'd0);

      // reset while the operation sits in ADD
      a        = 32'h3F800000;
      b        = 32'h40000000;
      op_sub   = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rm_out_valid", 64'(out_valid), 64'd0);
      check("rm_in_ready",  64'(in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("rm_no_output", 64'(out_valid), 64'd0);
      send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
      wait_idle();

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
